// File: rtl/gate_sweep_driver_pkg.sv
// Shared encodings for the gate sweep driver.
// State codes and common 2-input truth tables indexed by {A,B}.
package gate_sweep_driver_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  function automatic logic tt_bit(
    input logic [3:0] tt,
    input logic [1:0] idx
  );
    return tt[idx];
  endfunction

endpackage

// File: rtl/gate_sweep_driver_hold_timer.sv
// Hold window timer: counts clocks while enabled and flags
// the last cycle of each window, wrapping back to zero.
module hold_timer #(
  parameter int HOLD_CYCLES = 10,
  parameter int HOLD_W      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tc
);

  localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gate_sweep_driver.sv
// Sweeps {A,B} through 00..11 into a gate under test and
// checks the sampled Z against TRUTH_TABLE.
module gate_sweep_driver
  import gate_sweep_driver_pkg::*;
#(
  parameter int         HOLD_CYCLES = 10,
  parameter logic [3:0] TRUTH_TABLE = 4'b1110,
  parameter int         HOLD_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       Z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_fail_idx
);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end
  if ((2 ** HOLD_W) < HOLD_CYCLES) begin : g_bad_width
    $error("HOLD_W too narrow for HOLD_CYCLES");
  end

  state_t     state;
  logic [1:0] idx;
  logic       tc;
  logic       mismatch;
  logic [2:0] err_next;

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .HOLD_W     (HOLD_W)
  ) u_hold (
    .clk  (clk),
    .reset(reset),
    .clear(state != S_DRIVE),
    .tc   (tc)
  );

  assign mismatch = (Z != tt_bit(TRUTH_TABLE, idx));
  assign err_next = err_count + {2'b00, mismatch};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      A              <= 1'b0;
      B              <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          A    <= 1'b0;
          B    <= 1'b0;
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            state          <= S_DRIVE;
            idx            <= '0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
          end
        end
        S_DRIVE: begin
          if (tc) begin
            err_count <= err_next;
            if (mismatch && err_count == 3'd0) begin
              first_fail_idx <= idx;
            end
            if (idx == 2'd3) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              A     <= 1'b0;
              B     <= 1'b0;
              pass  <= (err_next == 3'd0);
            end else begin
              idx    <= idx + 2'd1;
              {A, B} <= idx + 2'd1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_driver.sv
// Bench for gate_sweep_driver: two instances (default and
// HOLD_CYCLES=1/AND) checked every cycle against a timeline model.
module tb_gate_sweep_driver;
  import gate_sweep_driver_pkg::*;

  localparam int H0 = 10;
  localparam int H1 = 1;
  localparam logic [3:0] T0 = TT_OR;
  localparam logic [3:0] T1 = TT_AND;

  logic clk = 1'b0;
  logic reset;
  logic start0, start1;
  logic [3:0] zt0, zt1;
  logic noise0, noise1;
  logic glitch0, glitch1;

  logic A0, B0, Z0, busy0, done0, pass0;
  logic A1, B1, Z1, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [1:0] ffi0, ffi1;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  assign Z0 = zt0[{A0, B0}] ^ noise0;
  assign Z1 = zt1[{A1, B1}] ^ noise1;

  gate_sweep_driver #(
    .HOLD_CYCLES(H0), .TRUTH_TABLE(T0), .HOLD_W(4)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start0),
    .A(A0), .B(B0), .Z(Z0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_idx(ffi0)
  );

  gate_sweep_driver #(
    .HOLD_CYCLES(H1), .TRUTH_TABLE(T1), .HOLD_W(1)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .A(A1), .B(B1), .Z(Z1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_idx(ffi1)
  );

  // Model: sweep is a timeline of t cycles since the start edge.
  bit mact[2];
  bit mdone[2];
  bit mpass[2];
  int mt[2];
  int merr[2];
  int mfirst[2];

  task automatic mstep(input int i, input bit rst,
                       input bit st, input bit z,
                       input int h, input logic [3:0] tt);
    int v;
    if (rst) begin
      mact[i] = 0; mdone[i] = 0; mpass[i] = 0;
      mt[i] = 0; merr[i] = 0; mfirst[i] = 0;
    end else if (mdone[i]) begin
      mdone[i] = 0;
    end else if (!mact[i]) begin
      if (st) begin
        mact[i] = 1; mt[i] = 0; merr[i] = 0;
        mfirst[i] = 0; mpass[i] = 0;
      end
    end else begin
      mt[i]++;
      if (mt[i] % h == 0) begin
        v = mt[i] / h - 1;
        if (z != tt[v]) begin
          merr[i]++;
          if (merr[i] == 1) mfirst[i] = v;
        end
        if (mt[i] == 4 * h) begin
          mact[i] = 0;
          mdone[i] = 1;
          mpass[i] = (merr[i] == 0);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    mstep(0, reset, start0, Z0, H0, T0);
    mstep(1, reset, start1, Z1, H1, T1);
  end

  function automatic logic [9:0] exp_vec(input int i, input int h);
    logic [1:0] ab;
    ab = mact[i] ? 2'(mt[i] / h) : 2'd0;
    return {ab, mact[i], mdone[i], mpass[i],
            3'(merr[i]), 2'(mfirst[i])};
  endfunction

  logic [9:0] act0, act1, e0, e1;
  assign act0 = {A0, B0, busy0, done0, pass0, err0, ffi0};
  assign act1 = {A1, B1, busy1, done1, pass1, err1, ffi1};

  function automatic bit quiet(input int i, input int h);
    return !(mact[i] && ((mt[i] + 1) % h == 0));
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      e0 = exp_vec(0, H0);
      e1 = exp_vec(1, H1);
      checks++;
      if (act0 !== e0) begin
        errors++;
        $display("FAIL model0 t=%0t got=%b want=%b", $time, act0, e0);
      end
      checks++;
      if (act1 !== e1) begin
        errors++;
        $display("FAIL model1 t=%0t got=%b want=%b", $time, act1, e1);
      end
    end
    noise0 = (glitch0 && quiet(0, H0)) ? 1'($urandom) : 1'b0;
    noise1 = (glitch1 && quiet(1, H1)) ? 1'($urandom) : 1'b0;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic sweep(input int i, input logic [3:0] zt,
                       input bit glitch, input bit rep,
                       output int lat);
    if (i == 0) begin zt0 = zt; glitch0 = glitch; end
    else begin zt1 = zt; glitch1 = glitch; end
    @(negedge clk);
    if (i == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    if (i == 0) start0 = 1'b0; else start1 = 1'b0;
    lat = 0;
    while (!(i == 0 ? done0 : done1) && lat < 200) begin
      if (i == 0) start0 = rep && (lat == 5 || lat == 20);
      @(negedge clk);
      lat++;
    end
    start0 = 1'b0;
    start1 = 1'b0;
    if (lat >= 200) begin
      $display("FAIL sweep%0d_timeout got=%0d want=done", i, lat);
    end
    @(negedge clk);
  endtask

  int lat;

  initial begin
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    zt0 = TT_OR; zt1 = TT_AND;
    glitch0 = 1'b0; glitch1 = 1'b0;
    noise0 = 1'b0; noise1 = 1'b0;
    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    chk("rst_busy", busy0, 0);
    chk("rst_ab", {A0, B0}, 0);
    chk("rst_err", err0, 0);
    chk("rst_pass", pass0, 0);
    reset = 1'b0;

    sweep(0, TT_OR, 0, 0, lat);
    chk("or_lat", lat, 40);
    chk("or_pass", pass0, 1);
    chk("or_err", err0, 0);

    sweep(0, 4'b0000, 0, 0, lat);
    chk("z0_lat", lat, 40);
    chk("z0_err", err0, 3);
    chk("z0_first", ffi0, 1);
    chk("z0_pass", pass0, 0);

    sweep(0, TT_OR, 0, 1, lat);
    chk("restart_lat", lat, 40);
    chk("restart_pass", pass0, 1);

    zt0 = 4'b1111;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_rst_err", err0, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_ab", {A0, B0}, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_err", err0, 0);
    sweep(0, TT_OR, 0, 0, lat);
    chk("post_rst_pass", pass0, 1);

    sweep(1, TT_AND, 0, 0, lat);
    chk("h1_lat", lat, 4);
    chk("h1_pass", pass1, 1);
    sweep(1, TT_OR, 0, 0, lat);
    chk("h1_or_err", err1, 2);
    chk("h1_or_first", ffi1, 1);

    sweep(0, 4'b1111, 0, 0, lat);
    chk("s1_err", err0, 1);
    chk("s1_first", ffi0, 0);
    chk("s1_pass", pass0, 0);
    sweep(0, TT_OR, 0, 0, lat);
    chk("b2b_err", err0, 0);
    chk("b2b_pass", pass0, 1);

    sweep(0, TT_OR, 1, 0, lat);
    chk("glitch_pass", pass0, 1);
    chk("glitch_lat", lat, 40);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      start0 = ($urandom_range(0, 7) == 0);
      start1 = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      glitch0 = 1'($urandom);
      glitch1 = 1'($urandom);
      if ($urandom_range(0, 59) == 0) zt0 = 4'($urandom);
      if ($urandom_range(0, 19) == 0) zt1 = 4'($urandom);
    end
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
